pry2oht_arbiter: RTL and testbench
==================================

# pry2oht_arbiter

Round-robin arbiter that shares one downstream resource (bus port, FIFO write port, shared datapath) between `WIDTH` requesters. It uses two `pry2oht_tree` priority-to-one-hot converters, one masked and one unmasked, to pick the next requester after the last one served. It holds a registered one-hot grant until the granted requester finishes its burst. It sits between the requesters' `req` lines and the resource's handshake, and drives the resource's input multiplexer select.

## Interface
- `WIDTH`, 8, number of requesters; must be a power of `SPLIT`.
- `SPLIT`, 2, tree split factor passed to `pry2oht_tree`.
- `IMPLEMENTATION`, 0, passed unchanged to `pry2oht_tree`.
- `LOCK`, 1, 1: grant held until `trn && lst`; 0: re-arbitrate after every `trn`.
- `WIDTH_LOG`, localparam, `$clog2(WIDTH)`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  WIDTH  per-requester request level.
- `trn`  in  1  transfer handshake of the shared resource (valid && ready) in this cycle.
- `lst`  in  1  last transfer of the burst; qualified by `trn`.
- `gnt`  out  WIDTH  registered one-hot grant; all zeros when idle.
- `vld`  out  1  grant active (equals `|gnt`).
- `idx`  out  WIDTH_LOG  binary index of the granted requester; holds its last value when idle.

## Operation
- State machine: `IDLE`, `BUSY`.
- Pointer `ptr` (WIDTH, one-hot) records the last requester served. Its reset value is bit `WIDTH-1`, so the first arbitration favours bit 0.
- Arbitration (combinational):
  - `msk[i] = 1` for every `i` strictly above the set bit of `ptr`.
  - `sel = |(req & msk) ? pry2oht(req & msk) : pry2oht(req)`, with rightmost (lowest index) priority.
- `IDLE`:
  - If `|req`: `gnt <= sel`, `idx <=` encoded `sel`, go to `BUSY`.
  - Otherwise stay in `IDLE`.
  - `trn`/`lst` are ignored in `IDLE`.
- `BUSY`: `gnt` and `idx` are held and `req` is not sampled.
  - A requester may drop `req` while granted; the grant still persists until the end condition.
- End condition: `trn && lst` when `LOCK=1`; `trn` when `LOCK=0`. On the end condition:
  - `ptr <= gnt`.
  - Re-arbitrate in the same cycle, using `gnt` as the pointer. The current owner wins again only if no other requester is active.
  - If `|req`: load the new `gnt` and stay in `BUSY` (no idle bubble).
  - Otherwise: `gnt <= 0`, go to `IDLE`.
- `lst` without `trn` has no effect.
- Requesters must keep `req` asserted until granted. A pulse that drops before it is sampled in `IDLE` or at an end condition is lost.

## Timing
- Reset (asynchronous assert, synchronous-to-`clk` release by the system): `gnt=0`, `vld=0`, `idx=0`, `ptr=1<<(WIDTH-1)`, state `IDLE`.
  - A reset mid-burst drops the grant immediately.
- Latency from `req` to `gnt` when idle: 1 cycle.
- Grant handover: the new `gnt` is visible in the cycle after the end-condition cycle, so back-to-back bursts have zero dead cycles.
- `gnt` is always one-hot or zero.
- The critical path is the masked and unmasked `pry2oht_tree`, followed by a WIDTH-wide 2:1 mux into the `gnt` register.

## Structure
- `pry2oht_pkg` holds the `arb_state_t` enum (`IDLE`, `BUSY`). It also holds the one-hot-to-binary function `oht2bin` used for `idx`, which is reusable by other `pry2oht_*` blocks.
- Sub-module: two instances of `pry2oht_tree` (masked and unmasked request vectors). No other hierarchy.

## Test plan
- Reset: drive `req=8'hFF` while `rst_n=0` -> `gnt=0`, `vld=0`, `idx=0`. After release -> `gnt=8'h01`, `idx=0` one cycle later.
- Handover: `req=8'b1000_0001`, grant `8'h01`, then pulse `trn&&lst` -> `gnt=8'h80` in the next cycle, no cycle with `vld=0`.
- Fairness: `req=8'hFF` held, one `trn&&lst` per grant -> grants in order `01,02,04,08,10,20,40,80,01`.
- Lock: with `gnt=8'h04`, apply `trn` without `lst` for 3 cycles while `req` toggles to `8'h02` -> `gnt` stays `8'h04`. Then `trn&&lst` -> `gnt=8'h02`.
- `LOCK=0`: `req=8'h06`, `trn` every cycle -> `gnt` alternates `02,04,02,04`.
- Mid-burst reset: assert `rst_n=0` while `gnt=8'h20` -> `gnt=0` without waiting for a `clk` edge. After release with `req=8'h21` -> `gnt=8'h01`.

Source files
------------

// File: rtl/pry2oht_pkg.sv
// Shared types and helpers for the pry2oht_* family.
//   arb_state_t : arbiter FSM state encoding (IDLE, BUSY)
//   OHT_MAX     : widest one-hot vector oht2bin accepts
//   oht2bin     : one-hot to binary index (OR-based encoder)
//   tree_levels : number of SPLIT-ary levels needed to cover WIDTH leaves
package pry2oht_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int OHT_MAX = 64;

  // For a valid one-hot input, ORing the indices of all set bits gives the
  // index of the single set bit. An all-zero input yields 0.
  function automatic int oht2bin(input logic [OHT_MAX-1:0] oht);
    int r;
    r = 0;
    for (int i = 0; i < OHT_MAX; i++) begin
      if (oht[i]) r = r | i;
    end
    return r;
  endfunction

  function automatic int tree_levels(input int w, input int s);
    int l;
    int n;
    l = 0;
    n = 1;
    while (n < w) begin
      n = n * s;
      l++;
    end
    return l;
  endfunction

endpackage

// File: rtl/pry2oht_arbiter_if.sv
// Bundle between the requesters/shared resource and the arbiter.
//   req : per-requester request level (held until granted)
//   trn : transfer handshake of the shared resource this cycle
//   lst : last transfer of the burst, only meaningful together with trn
//   gnt : registered one-hot grant, zero when idle
//   vld : grant active (|gnt)
//   idx : binary index of the granted requester, holds when idle
// Handshake: a transfer happens in a cycle exactly when trn is high (the
// resource's valid && ready). lst is qualified by trn; lst alone does nothing.
// The grant owner must keep driving the resource until trn && lst (or trn,
// when the arbiter re-arbitrates on every transfer).
interface pry2oht_arbiter_if #(
  parameter int WIDTH = 8
);
  localparam int WIDTH_LOG = $clog2(WIDTH);

  logic [WIDTH-1:0]     req;
  logic                 trn;
  logic                 lst;
  logic [WIDTH-1:0]     gnt;
  logic                 vld;
  logic [WIDTH_LOG-1:0] idx;

  // Requester/resource side.
  modport master (
    output req, trn, lst,
    input  gnt, vld, idx
  );

  // Arbiter side.
  modport slave (
    input  req, trn, lst,
    output gnt, vld, idx
  );

endinterface

// File: rtl/pry2oht_tree.sv
// Priority-to-one-hot converter with rightmost (lowest index) priority.
//   pry_i : request vector
//   oht_o : one-hot of the lowest set bit of pry_i, zero if pry_i is zero
// IMPLEMENTATION=0 builds a SPLIT-ary tree of group-OR terms: a bit is
// blocked if any lower sibling group at any level has a request.
// Any other IMPLEMENTATION uses the carry chain trick pry & -pry.
module pry2oht_tree
  import pry2oht_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int SPLIT          = 2,
  parameter int IMPLEMENTATION = 0
) (
  input  logic [WIDTH-1:0] pry_i,
  output logic [WIDTH-1:0] oht_o
);

  localparam int LEVELS = tree_levels(WIDTH, SPLIT);

  if (IMPLEMENTATION == 0) begin : g_tree
    // any_l[l][n] is the OR of the n-th group of SPLIT**l leaves. Entries past
    // the last real group stay zero, so they never block anything.
    logic [WIDTH-1:0] any_l [LEVELS+1];

    always_comb begin
      for (int l = 0; l <= LEVELS; l++) any_l[l] = '0;
      any_l[0] = pry_i;
      for (int l = 1; l <= LEVELS; l++) begin
        for (int n = 0; n < WIDTH; n++) begin
          for (int k = 0; k < SPLIT; k++) begin
            if (n * SPLIT + k < WIDTH) begin
              any_l[l][n] = any_l[l][n] | any_l[l-1][n*SPLIT+k];
            end
          end
        end
      end
    end

    always_comb begin
      logic blk;
      int   g;
      int   pos;
      int   base;
      oht_o = '0;
      for (int i = 0; i < WIDTH; i++) begin
        blk = 1'b0;
        g   = i;
        for (int l = 0; l < LEVELS; l++) begin
          pos  = g % SPLIT;
          base = g - pos;
          for (int k = 0; k < SPLIT; k++) begin
            if (k < pos) blk = blk | any_l[l][base+k];
          end
          g = g / SPLIT;
        end
        oht_o[i] = pry_i[i] & ~blk;
      end
    end
  end else begin : g_flat
    assign oht_o = pry_i & (~pry_i + WIDTH'(1));
  end

endmodule

// File: rtl/pry2oht_arbiter.sv
// Round-robin arbiter with a registered one-hot grant held for a burst.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   bus     : slave side of pry2oht_arbiter_if (req/trn/lst in, gnt/vld/idx out)
//   state_o : current FSM state, for observation
// A masked and an unmasked pry2oht_tree pick the first active requester above
// the last one served, wrapping to the lowest index when none is above.
module pry2oht_arbiter
  import pry2oht_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int SPLIT          = 2,
  parameter int IMPLEMENTATION = 0,
  parameter int LOCK           = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  pry2oht_arbiter_if.slave         bus,
  output arb_state_t               state_o
);

  localparam int WIDTH_LOG = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] PTR_RST = {1'b1, {(WIDTH-1){1'b0}}};

  arb_state_t           state_q, state_d;
  logic [WIDTH-1:0]     gnt_q, gnt_d;
  logic [WIDTH-1:0]     ptr_q, ptr_d;
  logic [WIDTH_LOG-1:0] idx_q, idx_d;

  logic                 end_c;
  logic [WIDTH-1:0]     arb_ptr;
  logic [WIDTH-1:0]     msk;
  logic [WIDTH-1:0]     req_m;
  logic [WIDTH-1:0]     oht_m;
  logic [WIDTH-1:0]     oht_u;
  logic [WIDTH-1:0]     sel;

  assign end_c = (LOCK != 0) ? (bus.trn & bus.lst) : bus.trn;

  // At the end of a burst the current owner is the pointer, even though
  // ptr_q only catches up on the same edge.
  assign arb_ptr = (state_q == BUSY && end_c) ? gnt_q : ptr_q;

  // Bits strictly above the pointer. With the pointer at the top bit the
  // shift wraps to zero, so the mask becomes empty.
  assign msk   = ~((arb_ptr << 1) - WIDTH'(1));
  assign req_m = bus.req & msk;

  pry2oht_tree #(
    .WIDTH          (WIDTH),
    .SPLIT          (SPLIT),
    .IMPLEMENTATION (IMPLEMENTATION)
  ) u_tree_msk (
    .pry_i (req_m),
    .oht_o (oht_m)
  );

  pry2oht_tree #(
    .WIDTH          (WIDTH),
    .SPLIT          (SPLIT),
    .IMPLEMENTATION (IMPLEMENTATION)
  ) u_tree_unm (
    .pry_i (bus.req),
    .oht_o (oht_u)
  );

  assign sel = (|req_m) ? oht_m : oht_u;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= PTR_RST;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          gnt_d   = sel;
          idx_d   = WIDTH_LOG'(oht2bin(OHT_MAX'(sel)));
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (end_c) begin
          ptr_d = gnt_q;
          if (|bus.req) begin
            gnt_d = sel;
            idx_d = WIDTH_LOG'(oht2bin(OHT_MAX'(sel)));
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    bus.gnt = gnt_q;
    bus.vld = |gnt_q;
    bus.idx = idx_q;
    state_o = state_q;
  end

endmodule

// File: tb/tb_pry2oht_arbiter.sv
module tb_pry2oht_arbiter;
  import pry2oht_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  pry2oht_arbiter_if #(.WIDTH(8)) a_if ();
  pry2oht_arbiter_if #(.WIDTH(8)) n_if ();
  arb_state_t a_state;
  arb_state_t n_state;

  pry2oht_arbiter #(
    .WIDTH(8), .SPLIT(2), .IMPLEMENTATION(0), .LOCK(1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (a_if),
    .state_o (a_state)
  );

  pry2oht_arbiter #(
    .WIDTH(8), .SPLIT(2), .IMPLEMENTATION(0), .LOCK(0)
  ) dut_nl (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (n_if),
    .state_o (n_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] req, input logic trn, input logic lst);
    a_if.req = req;
    a_if.trn = trn;
    a_if.lst = lst;
  endtask

  // Scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [7:0] g, input logic [2:0] i);
    chk({tag, "_gnt"}, 32'(a_if.gnt), 32'(g));
    chk({tag, "_vld"}, 32'(a_if.vld), 32'(|g));
    chk({tag, "_idx"}, 32'(a_if.idx), 32'(i));
  endtask

  initial begin
    logic [7:0] fair_exp [9];
    total = 0;
    bad   = 0;
    fair_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};

    // Reset with all requests active.
    rst_n = 1'b0;
    drive(8'hFF, 1'b0, 1'b0);
    n_if.req = 8'h00;
    n_if.trn = 1'b0;
    n_if.lst = 1'b0;
    #2;
    chk_a("rst", 8'h00, 3'd0);
    chk("rst_state", 32'(a_state), 32'(IDLE));
    step();
    step();
    chk_a("rst_hold", 8'h00, 3'd0);

    // Release: first arbitration favours bit 0.
    rst_n = 1'b1;
    step();
    chk_a("first", 8'h01, 3'd0);
    chk("first_state", 32'(a_state), 32'(BUSY));

    // Fairness with every requester active, one trn&&lst per grant.
    drive(8'hFF, 1'b1, 1'b1);
    for (int k = 0; k < 9; k++) begin
      step();
      chk_a($sformatf("fair%0d", k), fair_exp[k], 3'((k + 1) % 8));
    end
    // gnt is 02 here; hold without a transfer.
    drive(8'hFF, 1'b0, 1'b0);
    step();
    chk_a("hold", 8'h02, 3'd1);

    // Back to bit 0 owner, then handover 01 -> 80 with no idle cycle.
    drive(8'h01, 1'b1, 1'b1);
    step();
    chk_a("to01", 8'h01, 3'd0);
    drive(8'h81, 1'b1, 1'b1);
    step();
    chk_a("handover", 8'h80, 3'd7);
    step();
    chk_a("wrap", 8'h01, 3'd0);

    // Lock: owner 04 keeps the grant through transfers without lst.
    drive(8'h04, 1'b1, 1'b1);
    step();
    chk_a("lock_own", 8'h04, 3'd2);
    drive(8'h02, 1'b1, 1'b0);
    step();
    chk_a("lock0", 8'h04, 3'd2);
    drive(8'h00, 1'b1, 1'b0);
    step();
    chk_a("lock1", 8'h04, 3'd2);
    drive(8'h02, 1'b1, 1'b0);
    step();
    chk_a("lock2", 8'h04, 3'd2);
    drive(8'h02, 1'b1, 1'b1);
    step();
    chk_a("unlock", 8'h02, 3'd1);

    // lst without trn does nothing.
    drive(8'hFF, 1'b0, 1'b1);
    step();
    chk_a("lst_only", 8'h02, 3'd1);

    // Burst ends with no requests: idle, idx holds its last value.
    drive(8'h00, 1'b1, 1'b1);
    step();
    chk_a("to_idle", 8'h00, 3'd1);
    chk("idle_state", 32'(a_state), 32'(IDLE));
    step();
    chk_a("idle_ign", 8'h00, 3'd1);

    // Idle arbitration from pointer 02: 04 is above it, wins over 01.
    drive(8'h05, 1'b0, 1'b0);
    step();
    chk_a("idle_msk", 8'h04, 3'd2);

    // Owner wins again only when alone.
    drive(8'h04, 1'b1, 1'b1);
    step();
    chk_a("regrant", 8'h04, 3'd2);

    // Mid-burst reset drops the grant without a clock edge.
    drive(8'h20, 1'b1, 1'b1);
    step();
    chk_a("own20", 8'h20, 3'd5);
    drive(8'h20, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_a("async_rst", 8'h00, 3'd0);
    step();
    drive(8'h21, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    chk_a("post_rst", 8'h01, 3'd0);

    // LOCK=0 instance: re-arbitrate on every trn.
    n_if.req = 8'h06;
    n_if.trn = 1'b1;
    step();
    chk("nl0", 32'(n_if.gnt), 32'h02);
    step();
    chk("nl1", 32'(n_if.gnt), 32'h04);
    step();
    chk("nl2", 32'(n_if.gnt), 32'h02);
    step();
    chk("nl3", 32'(n_if.gnt), 32'h04);
    n_if.trn = 1'b0;
    step();
    chk("nl_hold", 32'(n_if.gnt), 32'h04);
    chk("nl_idx", 32'(n_if.idx), 32'd2);

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
